// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 burst initiator with command and user stream ports
module axi_burst_master #(
  parameter int DW  = 1024,
  parameter int AW  = 64,
  parameter int TCO = 1
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [DW-1:0] usr_wdata,
  input  logic          usr_wvalid,
  output logic          usr_wready,
  output logic [DW-1:0] usr_rdata,
  output logic          usr_rvalid,
  output logic          usr_rlast,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] AWADDR,
  output logic [7:0]    AWLEN,
  output logic          AWVALID,
  input  logic          AWREADY,
  output logic [DW-1:0] WDATA,
  output logic          WLAST,
  output logic          WVALID,
  input  logic          WREADY,
  input  logic          BVALID,
  output logic          BREADY,
  output logic [AW-1:0] ARADDR,
  output logic [7:0]    ARLEN,
  output logic          ARVALID,
  input  logic          ARREADY,
  input  logic [DW-1:0] RDATA,
  input  logic          RLAST,
  input  logic          RVALID,
  output logic          RREADY
);

  // Clock-to-out delay is a simulation-only notion; the logic itself is zero-delay.
  localparam int unused_tco = TCO;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AWR,
    S_WDAT,
    S_BRSP,
    S_ARD,
    S_RDAT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [8:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          awvalid_q, awvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          cmd_ready_q, cmd_ready_d;

  logic in_wdat;
  logic in_rdat;
  logic in_brsp;
  logic last_beat;
  logic w_fire;
  logic r_fire;

  // 9-bit counter compare so that len=255 is reached without wrapping.
  assign last_beat = (cnt_q == {1'b0, len_q});
  assign in_wdat   = (state_q == S_WDAT);
  assign in_rdat   = (state_q == S_RDAT);
  assign in_brsp   = (state_q == S_BRSP);

  assign WVALID     = in_wdat & usr_wvalid;
  assign WDATA      = in_wdat ? usr_wdata : '0;
  assign WLAST      = WVALID & last_beat;
  assign w_fire     = WVALID & WREADY;
  assign usr_wready = w_fire;

  assign RREADY     = in_rdat;
  assign r_fire     = in_rdat & RVALID;
  assign usr_rvalid = r_fire;
  assign usr_rdata  = r_fire ? RDATA : '0;
  assign usr_rlast  = r_fire & RLAST;

  assign BREADY = in_brsp;
  assign done   = (in_brsp & BVALID) | (r_fire & RLAST);
  assign err    = r_fire & RLAST & (err_q | ~last_beat);

  assign cmd_ready = cmd_ready_q;
  assign AWVALID   = awvalid_q;
  assign ARVALID   = arvalid_q;
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign AWLEN     = len_q;
  assign ARLEN     = len_q;

  // Next-state and next-register values for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    arvalid_d = arvalid_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (cmd_write) begin
            state_d   = S_AWR;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_ARD;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AWR: begin
        if (AWREADY) begin
          awvalid_d = 1'b0;
          state_d   = S_WDAT;
        end
      end
      S_WDAT: begin
        if (w_fire) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_BRSP;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_BRSP: begin
        if (BVALID) state_d = S_IDLE;
      end
      S_ARD: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RDAT;
        end
      end
      S_RDAT: begin
        if (RVALID) begin
          if (RLAST) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 9'd1;
            // Slave overran the requested length; remember it until RLAST.
            if (last_beat) err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_d = (state_d == S_IDLE);

  // State and registered outputs; async reset abandons any burst in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - scoreboard bench for axi_burst_master acting as the AXI slave
module tb_axi_burst_master;
  localparam int DW = 1024;
  localparam int AW = 64;
  typedef logic [DW-1:0] dw_t;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] usr_wdata;
  logic          usr_wvalid, usr_wready;
  logic [DW-1:0] usr_rdata;
  logic          usr_rvalid, usr_rlast, done, err;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;

  axi_burst_master #(.DW(DW), .AW(AW), .TCO(1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .usr_wdata(usr_wdata), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
    .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_rlast(usr_rlast),
    .done(done), .err(err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  dw_t mem [longint];
  dw_t wq[$];
  bit  wlq[$];
  dw_t rq[$];
  bit  rlq[$];
  bit  dq[$];

  task automatic check(input string tag, input dw_t got, input dw_t exp);
    dw_t g, e;
    g = got;
    e = exp;
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, g[127:0], e[127:0]);
    end
  endtask

  function automatic dw_t rnd();
    dw_t r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_slave();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; usr_wvalid = 1'b0; usr_wdata = '0;
  endtask

  task automatic send_cmd(input bit w, input longint addr, input int len);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("cmd_ready", dw_t'(cmd_ready), dw_t'(1'b1));
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_len = 8'(len);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic pop_done();
    if (dq.size() == 0) begin
      check("spurious_done", dw_t'(done), dw_t'(1'b0));
    end else begin
      check("done_err", dw_t'(err), dw_t'(dq.pop_front()));
    end
  endtask

  task automatic do_write(input longint addr, input int len, input int aw_delay, input bit gaps);
    dw_t beats[$];
    dw_t d;
    int  sent;
    bit  aw_seen, b_pend, fin;
    sent = 0; aw_seen = 0; b_pend = 0; fin = 0;
    for (int i = 0; i <= len; i++) begin
      d = rnd();
      beats.push_back(d);
      wq.push_back(d);
      wlq.push_back(i == len);
      mem[addr + longint'(i)] = d;
    end
    dq.push_back(1'b0);
    send_cmd(1'b1, addr, len);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      AWREADY    = (cyc >= aw_delay);
      WREADY     = 1'b1;
      usr_wvalid = (sent <= len) && !(gaps && (cyc % 2 == 1));
      usr_wdata  = (sent <= len) ? beats[sent] : '0;
      BVALID     = b_pend;
      #1;
      if (!aw_seen && cyc < aw_delay) check("awvalid_hold", dw_t'(AWVALID), dw_t'(1'b1));
      if (AWVALID && AWREADY) begin
        check("awaddr", dw_t'(AWADDR), dw_t'(addr));
        check("awlen", dw_t'(AWLEN), dw_t'(len));
        aw_seen = 1;
      end
      if (WVALID && WREADY) begin
        check("usr_wready", dw_t'(usr_wready), dw_t'(1'b1));
        if (wq.size() == 0) begin
          check("w_extra_beat", dw_t'(WVALID), dw_t'(1'b0));
        end else begin
          check("wdata", WDATA, wq.pop_front());
          check("wlast", dw_t'(WLAST), dw_t'(wlq.pop_front()));
        end
        if (WLAST) b_pend = 1;
        sent++;
      end
      if (done) begin
        pop_done();
        b_pend = 0;
        fin = 1;
      end
      @(negedge ACLK);
    end
    check("wr_complete", dw_t'(fin), dw_t'(1'b1));
    check("aw_seen", dw_t'(aw_seen), dw_t'(1'b1));
    check("w_beats", dw_t'(sent), dw_t'(len + 1));
    idle_slave();
  endtask

  task automatic do_read(input longint addr, input int len, input int last_at, input bit exp_err);
    int beat;
    bit ar_done, fin;
    beat = 0; ar_done = 0; fin = 0;
    for (int i = 0; i <= last_at; i++) begin
      rq.push_back(mem[addr + longint'(i)]);
      rlq.push_back(i == last_at);
    end
    dq.push_back(exp_err);
    send_cmd(1'b0, addr, len);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      ARREADY = 1'b1;
      RVALID  = ar_done && (beat <= last_at);
      RDATA   = RVALID ? mem[addr + longint'(beat)] : '0;
      RLAST   = RVALID && (beat == last_at);
      #1;
      if (ARVALID && ARREADY) begin
        check("araddr", dw_t'(ARADDR), dw_t'(addr));
        check("arlen", dw_t'(ARLEN), dw_t'(len));
        ar_done = 1;
      end
      if (RVALID && RREADY) begin
        check("usr_rvalid", dw_t'(usr_rvalid), dw_t'(1'b1));
        check("usr_rdata", usr_rdata, rq.pop_front());
        check("usr_rlast", dw_t'(usr_rlast), dw_t'(rlq.pop_front()));
        beat++;
      end
      if (done) begin
        pop_done();
        fin = 1;
      end
      @(negedge ACLK);
    end
    check("rd_complete", dw_t'(fin), dw_t'(1'b1));
    check("r_beats", dw_t'(beat), dw_t'(last_at + 1));
    idle_slave();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, dw_t'(AWVALID), '0);
    check({tag, "_wvalid"}, dw_t'(WVALID), '0);
    check({tag, "_wlast"}, dw_t'(WLAST), '0);
    check({tag, "_wdata"}, WDATA, '0);
    check({tag, "_bready"}, dw_t'(BREADY), '0);
    check({tag, "_arvalid"}, dw_t'(ARVALID), '0);
    check({tag, "_rready"}, dw_t'(RREADY), '0);
    check({tag, "_usr_wready"}, dw_t'(usr_wready), '0);
    check({tag, "_usr_rvalid"}, dw_t'(usr_rvalid), '0);
    check({tag, "_done"}, dw_t'(done), '0);
    check({tag, "_cmd_ready"}, dw_t'(cmd_ready), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dn_seen;
    int n;
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    idle_slave();
    #1;
    check_all_zero("rst");
    #20;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    #1;
    check("cmd_ready_after_rst", dw_t'(cmd_ready), dw_t'(1'b1));

    do_write(64'h4, 3, 0, 1'b0);
    do_read(64'h4, 3, 3, 1'b0);
    do_write(64'h100, 0, 2, 1'b0);
    do_read(64'h100, 0, 0, 1'b0);
    do_write(64'h200, 7, 0, 1'b1);
    do_read(64'h200, 7, 7, 1'b0);
    do_read(64'h4, 3, 1, 1'b1);
    do_read(64'h4, 1, 2, 1'b1);

    // Abandon a write burst mid-data with an asynchronous reset.
    dn_seen = 0;
    send_cmd(1'b1, 64'h40, 3);
    for (int cyc = 0; cyc < 4; cyc++) begin
      AWREADY = 1'b1; WREADY = 1'b1; usr_wvalid = 1'b1; usr_wdata = rnd();
      #1;
      if (done) dn_seen = 1;
      @(negedge ACLK);
    end
    ARESETn = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge ACLK);
    idle_slave();
    ARESETn = 1'b1;
    n = 0;
    #1;
    while (!cmd_ready && n < 10) begin
      if (done) dn_seen = 1;
      @(negedge ACLK);
      #1;
      n++;
    end
    check("cmd_ready_after_midrst", dw_t'(cmd_ready), dw_t'(1'b1));
    check("no_done_after_abort", dw_t'(dn_seen), dw_t'(1'b0));

    do_write(64'h300, 2, 1, 1'b0);
    do_read(64'h300, 2, 2, 1'b0);

    check("scoreboard_empty", dw_t'(wq.size() + rq.size() + dq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
